// File: rtl/plic_gateway.sv
// plic_gateway: interrupt gateway placed in front of the PLIC.
//   - Synchronises raw interrupt lines (2 flops) and applies per-source
//     polarity (POL) and level/edge trigger mode (TRIG).
//   - Runs a per-source IDLE/PENDING/INFLIGHT lifecycle driven by claim and
//     complete events; irq_pending feeds the PLIC irq_sources inputs.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   waddr/wdata/wstrb/wen         register write port (byte strobes)
//   raddr/rdata                   register read port, 1-cycle registered data
//   irq_in                        raw asynchronous interrupt lines
//   claim_valid/claim_id          claim of a source this cycle
//   complete_valid/complete_id    completion of a source this cycle
//   irq_pending                   registered per-source pending vector
// Register map: 0x0 TRIG (RW), 0x4 POL (RW), 0x8 PEND (RO), 0xC INFL (RO).
module plic_gateway #(
  parameter int NUM_SOURCES = 8,
  parameter int ID_W        = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wen,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]  rdata,
  input  logic [NUM_SOURCES-1:0] irq_in,
  input  logic                   claim_valid,
  input  logic [ID_W-1:0]        claim_id,
  input  logic                   complete_valid,
  input  logic [ID_W-1:0]        complete_id,
  output logic [NUM_SOURCES-1:0] irq_pending
);

  localparam logic [ADDR_WIDTH-1:0] A_TRIG = ADDR_WIDTH'(16'h0000);
  localparam logic [ADDR_WIDTH-1:0] A_POL  = ADDR_WIDTH'(16'h0004);
  localparam logic [ADDR_WIDTH-1:0] A_PEND = ADDR_WIDTH'(16'h0008);
  localparam logic [ADDR_WIDTH-1:0] A_INFL = ADDR_WIDTH'(16'h000C);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_INFL = 2'd2
  } state_e;

  // Expand byte strobes into a bit mask over the data word.
  function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return DATA_WIDTH'(m);
  endfunction

  logic [NUM_SOURCES-1:0] s1_q, s2_q, prev_q;
  logic [NUM_SOURCES-1:0] trig_q, trig_d, pol_q, pol_d;
  logic [NUM_SOURCES-1:0] edge_lat_q, edge_lat_d;
  logic [NUM_SOURCES-1:0] irq_pending_q, irq_pending_d;
  logic [NUM_SOURCES-1:0] act_s, rise_s, infl_s, trig_clr_s;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]  mask_s, trig_wr_s, pol_wr_s;
  logic                   unused_s;
  state_e                 state_q [NUM_SOURCES];
  state_e                 state_d [NUM_SOURCES];

  assign act_s  = s2_q ^ pol_q;
  assign rise_s = act_s & ~prev_q;

  assign mask_s    = strb_mask(wstrb);
  assign trig_wr_s = (DATA_WIDTH'(trig_q) & ~mask_s) | (wdata & mask_s);
  assign pol_wr_s  = (DATA_WIDTH'(pol_q) & ~mask_s) | (wdata & mask_s);
  // Bits above NUM_SOURCES are deliberately dropped.
  assign unused_s  = ^{trig_wr_s, pol_wr_s};

  // Config register next-state and TRIG-cleared edge latches.
  always_comb begin
    trig_d     = trig_q;
    pol_d      = pol_q;
    trig_clr_s = '0;
    if (wen && waddr == A_TRIG) begin
      trig_d     = trig_wr_s[NUM_SOURCES-1:0];
      trig_clr_s = mask_s[NUM_SOURCES-1:0] & ~wdata[NUM_SOURCES-1:0];
    end else if (wen && waddr == A_POL) begin
      pol_d = pol_wr_s[NUM_SOURCES-1:0];
    end else begin
      trig_d = trig_q;
    end
  end

  // Per-source lifecycle next-state and edge latch update.
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      logic claim_hit, comp_hit, edge_evt;
      claim_hit     = claim_valid && (int'(claim_id) == i);
      comp_hit      = complete_valid && (int'(complete_id) == i);
      edge_evt      = trig_q[i] & rise_s[i];
      state_d[i]    = state_q[i];
      edge_lat_d[i] = edge_lat_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (trig_q[i] ? rise_s[i] : act_s[i]) state_d[i] = ST_PEND;
          else                                  state_d[i] = ST_IDLE;
        end
        ST_PEND: begin
          if (claim_hit)                    state_d[i] = ST_INFL;
          else if (!trig_q[i] && !act_s[i]) state_d[i] = ST_IDLE;
          else                              state_d[i] = ST_PEND;
        end
        ST_INFL: begin
          // An edge arriving in the completion cycle is not lost.
          if (comp_hit) begin
            state_d[i]    = (edge_lat_q[i] || edge_evt) ? ST_PEND : ST_IDLE;
            edge_lat_d[i] = 1'b0;
          end else if (edge_evt) begin
            edge_lat_d[i] = 1'b1;
          end else begin
            state_d[i] = ST_INFL;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
      if (trig_clr_s[i]) edge_lat_d[i] = 1'b0;
    end
  end

  // Output decode: pending is registered from next state for 3-edge latency.
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      irq_pending_d[i] = (state_d[i] == ST_PEND);
      infl_s[i]        = (state_q[i] == ST_INFL);
    end
  end

  // Register read mux.
  always_comb begin
    rdata_d = '0;
    case (raddr)
      A_TRIG:  rdata_d = DATA_WIDTH'(trig_q);
      A_POL:   rdata_d = DATA_WIDTH'(pol_q);
      A_PEND:  rdata_d = DATA_WIDTH'(irq_pending_q);
      A_INFL:  rdata_d = DATA_WIDTH'(infl_s);
      default: rdata_d = '0;
    endcase
  end

  // State register: synchronisers, config, lifecycle and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      prev_q        <= '0;
      trig_q        <= '0;
      pol_q         <= '0;
      edge_lat_q    <= '0;
      irq_pending_q <= '0;
      rdata_q       <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) state_q[i] <= ST_IDLE;
    end else begin
      s1_q          <= irq_in;
      s2_q          <= s1_q;
      prev_q        <= act_s;
      trig_q        <= trig_d;
      pol_q         <= pol_d;
      edge_lat_q    <= edge_lat_d;
      irq_pending_q <= irq_pending_d;
      rdata_q       <= rdata_d;
      for (int i = 0; i < NUM_SOURCES; i++) state_q[i] <= state_d[i];
    end
  end

  assign rdata       = rdata_q;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_plic_gateway.sv
module tb_plic_gateway;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] waddr, raddr;
  logic [31:0] wdata, rdata, rd_val;
  logic [3:0]  wstrb;
  logic        wen;
  logic [7:0]  irq_in, irq_pending;
  logic        claim_valid, complete_valid;
  logic [2:0]  claim_id, complete_id;
  int          n_cmp = 0;
  int          n_err = 0;

  plic_gateway dut (
    .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .wen(wen), .raddr(raddr), .rdata(rdata), .irq_in(irq_in),
    .claim_valid(claim_valid), .claim_id(claim_id),
    .complete_valid(complete_valid), .complete_id(complete_id),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    waddr = a; wdata = d; wstrb = 4'hF; wen = 1'b1;
    step(1);
    wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    raddr = a;
    step(1);
    d = rdata;
  endtask

  task automatic claim(input logic [2:0] id);
    claim_valid = 1'b1; claim_id = id;
    step(1);
    claim_valid = 1'b0;
  endtask

  task automatic complete(input logic [2:0] id);
    complete_valid = 1'b1; complete_id = id;
    step(1);
    complete_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; irq_in = '0; wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    raddr = '0; claim_valid = 1'b0; claim_id = '0;
    complete_valid = 1'b0; complete_id = '0;
    step(2);
    n_cmp++; if (irq_pending !== 8'h00) begin n_err++; $display("FAIL reset_pend: got %h want 00", irq_pending); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    rst = 1'b0;
    step(1);
    rd(16'h0004, rd_val);
    n_cmp++; if (rd_val !== 32'h0) begin n_err++; $display("FAIL reset_pol: got %h want 0", rd_val); end
  endtask

  task automatic test_level;
    wr(16'h0000, 32'h0);
    rd(16'h0000, rd_val);
    n_cmp++; if (rd_val !== 32'h0) begin n_err++; $display("FAIL trig_rb: got %h want 0", rd_val); end
    irq_in[0] = 1'b1;
    step(2);
    n_cmp++; if (irq_pending[0] !== 1'b0) begin n_err++; $display("FAIL lat_edge2: got %b want 0", irq_pending[0]); end
    step(1);
    n_cmp++; if (irq_pending[0] !== 1'b1) begin n_err++; $display("FAIL lat_edge3: got %b want 1", irq_pending[0]); end
    rd(16'h0008, rd_val);
    n_cmp++; if (rd_val !== 32'h01) begin n_err++; $display("FAIL pend_rd: got %h want 01", rd_val); end
    irq_in[0] = 1'b0;
    step(3);
    // level source 2 drops before claim
    irq_in[2] = 1'b1;
    step(3);
    n_cmp++; if (irq_pending !== 8'h04) begin n_err++; $display("FAIL lvl2_set: got %h want 04", irq_pending); end
    irq_in[2] = 1'b0;
    step(2);
    n_cmp++; if (irq_pending[2] !== 1'b1) begin n_err++; $display("FAIL lvl2_hold: got %b want 1", irq_pending[2]); end
    step(1);
    n_cmp++; if (irq_pending[2] !== 1'b0) begin n_err++; $display("FAIL lvl2_drop: got %b want 0", irq_pending[2]); end
  endtask

  task automatic test_edge;
    wr(16'h0000, 32'h08);
    rd(16'h0000, rd_val);
    n_cmp++; if (rd_val !== 32'h08) begin n_err++; $display("FAIL trig_rb8: got %h want 08", rd_val); end
    irq_in[3] = 1'b1; step(2); irq_in[3] = 1'b0; step(3);
    n_cmp++; if (irq_pending !== 8'h08) begin n_err++; $display("FAIL edge_pend: got %h want 08", irq_pending); end
    claim(3'd3);
    n_cmp++; if (irq_pending[3] !== 1'b0) begin n_err++; $display("FAIL edge_claim: got %b want 0", irq_pending[3]); end
    rd(16'h000C, rd_val);
    n_cmp++; if (rd_val !== 32'h08) begin n_err++; $display("FAIL edge_infl: got %h want 08", rd_val); end
    irq_in[3] = 1'b1; step(2); irq_in[3] = 1'b0; step(3);
    n_cmp++; if (irq_pending[3] !== 1'b0) begin n_err++; $display("FAIL edge_absorb: got %b want 0", irq_pending[3]); end
    complete(3'd3);
    n_cmp++; if (irq_pending[3] !== 1'b1) begin n_err++; $display("FAIL edge_repend: got %b want 1", irq_pending[3]); end
    claim(3'd3);
    complete(3'd3);
    n_cmp++; if (irq_pending[3] !== 1'b0) begin n_err++; $display("FAIL edge_idle: got %b want 0", irq_pending[3]); end
    rd(16'h000C, rd_val);
    n_cmp++; if (rd_val !== 32'h0) begin n_err++; $display("FAIL edge_infl0: got %h want 0", rd_val); end
  endtask

  task automatic test_polarity;
    wr(16'h0004, 32'h80);
    step(1);
    n_cmp++; if (irq_pending[7] !== 1'b1) begin n_err++; $display("FAIL pol_pend: got %b want 1", irq_pending[7]); end
    rd(16'h0004, rd_val);
    n_cmp++; if (rd_val !== 32'h80) begin n_err++; $display("FAIL pol_rb: got %h want 80", rd_val); end
    claim(3'd7);
    n_cmp++; if (irq_pending[7] !== 1'b0) begin n_err++; $display("FAIL pol_claim: got %b want 0", irq_pending[7]); end
    complete(3'd7);
    n_cmp++; if (irq_pending[7] !== 1'b0) begin n_err++; $display("FAIL pol_idle: got %b want 0", irq_pending[7]); end
    step(1);
    n_cmp++; if (irq_pending[7] !== 1'b1) begin n_err++; $display("FAIL pol_repend: got %b want 1", irq_pending[7]); end
  endtask

  task automatic test_same_cycle;
    irq_in[1] = 1'b1; irq_in[5] = 1'b1;
    step(3);
    n_cmp++; if (irq_pending !== 8'hA2) begin n_err++; $display("FAIL sc_setup: got %h want a2", irq_pending); end
    claim(3'd5);
    irq_in[5] = 1'b0;
    step(3);
    claim_valid = 1'b1; claim_id = 3'd1;
    complete_valid = 1'b1; complete_id = 3'd5;
    step(1);
    claim_valid = 1'b0; complete_valid = 1'b0;
    n_cmp++; if (irq_pending !== 8'h80) begin n_err++; $display("FAIL sc_pend: got %h want 80", irq_pending); end
    rd(16'h000C, rd_val);
    n_cmp++; if (rd_val !== 32'h02) begin n_err++; $display("FAIL sc_infl: got %h want 02", rd_val); end
    claim(3'd6);
    complete(3'd7);
    n_cmp++; if (irq_pending !== 8'h80) begin n_err++; $display("FAIL sc_ignore: got %h want 80", irq_pending); end
    rd(16'h000C, rd_val);
    n_cmp++; if (rd_val !== 32'h02) begin n_err++; $display("FAIL sc_infl2: got %h want 02", rd_val); end
  endtask

  task automatic test_reset_mid;
    irq_in[4] = 1'b1;
    step(3);
    claim(3'd4);
    rd(16'h000C, rd_val);
    n_cmp++; if (rd_val !== 32'h12) begin n_err++; $display("FAIL rm_infl: got %h want 12", rd_val); end
    irq_in = '0;
    rst = 1'b1;
    #1;
    n_cmp++; if (irq_pending !== 8'h00) begin n_err++; $display("FAIL rm_pend: got %h want 00", irq_pending); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rm_rdata: got %h want 0", rdata); end
    step(1);
    rst = 1'b0;
    rd(16'h0008, rd_val);
    n_cmp++; if (rd_val !== 32'h0) begin n_err++; $display("FAIL rm_pendrd: got %h want 0", rd_val); end
    rd(16'h000C, rd_val);
    n_cmp++; if (rd_val !== 32'h0) begin n_err++; $display("FAIL rm_inflrd: got %h want 0", rd_val); end
    rd(16'h0000, rd_val);
    n_cmp++; if (rd_val !== 32'h0) begin n_err++; $display("FAIL rm_trig: got %h want 0", rd_val); end
    rd(16'h0004, rd_val);
    n_cmp++; if (rd_val !== 32'h0) begin n_err++; $display("FAIL rm_pol: got %h want 0", rd_val); end
  endtask

  initial begin
    test_reset;
    test_level;
    test_edge;
    test_polarity;
    test_same_cycle;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
